fx_pt_mul_pipe: RTL and testbench



---
 rtl/fx_pt_mul_pipe.sv | 117 +++++++++++
 tb/tb_fx_pt_mul_pipe.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fx_pt_mul_pipe.sv
// Three-stage unsigned fixed-point multiplier with valid/ready on both sides.
// Each result is either truncated or rounded half-up, then saturated to one word.
module fx_pt_mul_pipe #(
  parameter int INT_LEN  = 4,
  parameter int FRAC_LEN = 17
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [INT_LEN+FRAC_LEN-1:0]       in1,
  input  logic [INT_LEN+FRAC_LEN-1:0]       in2,
  input  logic                              round_mode,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [INT_LEN+FRAC_LEN-1:0]       out,
  output logic                              out_ovf,
  output logic                              ovf_sticky,
  input  logic                              clr_sticky
);

  localparam int WORD_LEN = INT_LEN + FRAC_LEN;
  localparam int PROD_LEN = 2 * WORD_LEN;
  localparam int RND_LEN  = WORD_LEN + INT_LEN + 1;

  logic                r_v1, r_v2, r_v3;
  logic [WORD_LEN-1:0] r_a, r_b;
  logic                r_rm1, r_rm2;
  logic [PROD_LEN-1:0] r_p;
  logic [WORD_LEN-1:0] r_out;
  logic                r_ovf;
  logic                r_sticky;

  logic                w_ld1, w_ld2, w_ld3;
  logic                w_out_xfer;
  logic [PROD_LEN-1:0] w_prod;
  logic [RND_LEN-1:0]  w_rnd;
  logic                w_sat;
  logic                w_unused;

  // A stage can take new data when empty or when its occupant moves on this cycle.
  assign w_out_xfer = r_v3 & out_ready;
  assign w_ld3      = ~r_v3 | out_ready;
  assign w_ld2      = ~r_v2 | w_ld3;
  assign w_ld1      = ~r_v1 | w_ld2;
  assign in_ready   = w_ld1;

  assign w_prod = {{WORD_LEN{1'b0}}, r_a} * {{WORD_LEN{1'b0}}, r_b};

  // One extra top bit keeps the rounding carry so it can trigger saturation.
  assign w_rnd = {1'b0, r_p[PROD_LEN-1:FRAC_LEN]}
               + {{(RND_LEN-1){1'b0}}, r_rm2 & r_p[FRAC_LEN-1]};
  assign w_sat = |w_rnd[RND_LEN-1:WORD_LEN];

  assign w_unused = ^r_p[FRAC_LEN-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1  <= 1'b0;
      r_a   <= '0;
      r_b   <= '0;
      r_rm1 <= 1'b0;
    end else if (w_ld1) begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_a   <= in1;
        r_b   <= in2;
        r_rm1 <= round_mode;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2  <= 1'b0;
      r_p   <= '0;
      r_rm2 <= 1'b0;
    end else if (w_ld2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_p   <= w_prod;
        r_rm2 <= r_rm1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v3  <= 1'b0;
      r_out <= '0;
      r_ovf <= 1'b0;
    end else if (w_ld3) begin
      r_v3 <= r_v2;
      if (r_v2) begin
        r_out <= w_sat ? {WORD_LEN{1'b1}} : w_rnd[WORD_LEN-1:0];
        r_ovf <= w_sat;
      end
    end
  end

  // Only delivered results count; a set in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= 1'b0;
    end else if (w_out_xfer && r_ovf) begin
      r_sticky <= 1'b1;
    end else if (clr_sticky) begin
      r_sticky <= 1'b0;
    end
  end

  assign out_valid  = r_v3;
  assign out        = r_out;
  assign out_ovf    = r_ovf;
  assign ovf_sticky = r_sticky;

endmodule

// File: tb/tb_fx_pt_mul_pipe.sv
// Directed bench for fx_pt_mul_pipe: hand-computed Q4.17 products, stalls,
// sticky overflow behaviour and asynchronous reset with entries in flight.
module tb_fx_pt_mul_pipe;

  localparam int W = 21;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, round_mode;
  logic [W-1:0] in1, in2, out;
  logic         out_valid, out_ready, out_ovf, ovf_sticky, clr_sticky;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] va [8];
  logic [W-1:0] vb [8];
  logic         vr [8];
  logic [W-1:0] vo [8];
  logic         vf [8];

  logic [W-1:0] exp_q [$];
  logic         expf_q[$];
  int           acc_q [$];

  always #5 clk = ~clk;

  fx_pt_mul_pipe dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in1        (in1),
    .in2        (in2),
    .round_mode (round_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out        (out),
    .out_ovf    (out_ovf),
    .ovf_sticky (ovf_sticky),
    .clr_sticky (clr_sticky)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_vec(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic rm, input logic [W-1:0] o, input logic f);
    va[i] = a; vb[i] = b; vr[i] = rm; vo[i] = o; vf[i] = f;
  endtask

  // Feeds vectors 0..n-1; out_ready is low on cycles lo..hi of the run.
  task automatic run(input int n, input int lo, input int hi, input bit lat);
    int idx = 0;
    int got = 0;
    int cyc = 0;
    bit stall_prev = 0;
    bit seen_full = 0;
    bit set_pend = 0;
    logic [W-1:0] h_out = '0;
    logic h_ovf = 1'b0;
    while (got < n && cyc < 200) begin
      in_valid   = (idx < n);
      in1        = (idx < n) ? va[idx] : '0;
      in2        = (idx < n) ? vb[idx] : '0;
      round_mode = (idx < n) ? vr[idx] : 1'b0;
      out_ready  = !(cyc >= lo && cyc <= hi);
      #1;
      if (set_pend) begin
        chk("sticky_set", {31'd0, ovf_sticky}, 32'd1);
        set_pend = 0;
      end
      if (stall_prev) begin
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_out", {11'd0, out}, {11'd0, h_out});
        chk("stall_ovf", {31'd0, out_ovf}, {31'd0, h_ovf});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", 32'd1, 32'd0);
        end else begin
          int a_cyc;
          logic [W-1:0] eo;
          logic ef;
          eo = exp_q.pop_front();
          ef = expf_q.pop_front();
          a_cyc = acc_q.pop_front();
          chk($sformatf("out[%0d]", got), {11'd0, out}, {11'd0, eo});
          chk($sformatf("ovf[%0d]", got), {31'd0, out_ovf}, {31'd0, ef});
          if (lat) chk("latency", cyc - a_cyc, 32'd3);
        end
        if (out_ovf) set_pend = 1;
        got++;
      end
      if (in_valid && !in_ready && !seen_full) begin
        seen_full = 1;
        chk("full_depth", exp_q.size(), 32'd3);
      end
      stall_prev = out_valid && !out_ready;
      h_out = out;
      h_ovf = out_ovf;
      if (in_valid && in_ready) begin
        exp_q.push_back(vo[idx]);
        expf_q.push_back(vf[idx]);
        acc_q.push_back(cyc);
        idx++;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    if (got < n) chk("timeout", got, n);
  endtask

  initial begin
    bit stale;
    rst_n = 1'b0; in_valid = 1'b0; in1 = '0; in2 = '0; round_mode = 1'b0;
    out_ready = 1'b1; clr_sticky = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out", {11'd0, out}, 32'd0);
    chk("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
    chk("rst_sticky", {31'd0, ovf_sticky}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1.5 * 2.0 = 3.0
    set_vec(0, 21'h030000, 21'h040000, 1'b0, 21'h060000, 1'b0);
    run(1, -1, -1, 1);

    // smallest product below one LSB: truncated to 0, rounded up to 1
    set_vec(0, 21'h000001, 21'h010000, 1'b0, 21'h000000, 1'b0);
    set_vec(1, 21'h000001, 21'h010000, 1'b1, 21'h000001, 1'b0);
    run(2, -1, -1, 1);
    chk("sticky_idle", {31'd0, ovf_sticky}, 32'd0);

    // 8.0 * 2.0 = 16.0 saturates
    set_vec(0, 21'h100000, 21'h040000, 1'b0, 21'h1FFFFF, 1'b1);
    run(1, -1, -1, 1);

    // 0x155555 * 1.5 = 0x1FFFFF.8: truncate fits, rounding carry overflows
    set_vec(0, 21'h155555, 21'h030000, 1'b0, 21'h1FFFFF, 1'b0);
    set_vec(1, 21'h155555, 21'h030000, 1'b1, 21'h1FFFFF, 1'b1);
    run(2, -1, -1, 1);

    clr_sticky = 1'b1;
    @(negedge clk);
    clr_sticky = 1'b0;
    #1;
    chk("sticky_clr", {31'd0, ovf_sticky}, 32'd0);
    @(negedge clk);

    // back-to-back stream with a stall; clear held high so set-vs-clear is exercised
    set_vec(0, 21'h020000, 21'h020000, 1'b0, 21'h020000, 1'b0);
    set_vec(1, 21'h030000, 21'h040000, 1'b0, 21'h060000, 1'b0);
    set_vec(2, 21'h100000, 21'h040000, 1'b0, 21'h1FFFFF, 1'b1);
    set_vec(3, 21'h000001, 21'h010000, 1'b1, 21'h000001, 1'b0);
    set_vec(4, 21'h040000, 21'h040000, 1'b0, 21'h080000, 1'b0);
    set_vec(5, 21'h155555, 21'h030000, 1'b0, 21'h1FFFFF, 1'b0);
    clr_sticky = 1'b1;
    run(6, 2, 7, 0);
    #1;
    chk("sticky_cleared_after", {31'd0, ovf_sticky}, 32'd0);
    clr_sticky = 1'b0;
    @(negedge clk);

    // set sticky, fill the pipe under stall, then reset asynchronously
    set_vec(0, 21'h100000, 21'h040000, 1'b0, 21'h1FFFFF, 1'b1);
    run(1, -1, -1, 0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in1 = 21'h030000; in2 = 21'h040000; round_mode = 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_out", {11'd0, out}, 32'd0);
    chk("arst_sticky", {31'd0, ovf_sticky}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    exp_q.delete(); expf_q.delete(); acc_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (out_valid) stale = 1;
      @(negedge clk);
    end
    chk("no_stale", {31'd0, stale}, 32'd0);

    set_vec(0, 21'h040000, 21'h040000, 1'b1, 21'h080000, 1'b0);
    run(1, -1, -1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
